// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter state encoding and default frame constants
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int STOP_BITS  = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - even/odd parity of a word
module uart_parity_gen #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = (^data) ^ ODD;

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - oversampled UART transmitter popping words from a FWFT FIFO
module uart_tx_param #(
  parameter int DATA_BITS  = uart_pkg::DATA_BITS,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = uart_pkg::STOP_BITS
) (
  input  logic                 CLK288MHZ,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] dataIn,
  input  logic                 fifoNE,
  output logic                 readEn,
  output logic                 uart_txd_in,
  output logic                 busy,
  output logic                 txDone
);
  import uart_pkg::*;

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  uart_state_t          state, state_next;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 parity_q, parity_w;
  logic                 last_tick, frame_end, pop, txd_next;

  assign last_tick = tick && (tick_cnt == TICK_LAST);
  assign frame_end = (state == STOP) && last_tick && (bit_cnt == STOP_LAST);
  // Gated by reset so the FIFO is never popped while the block is held in reset.
  assign pop       = fifoNE && !reset && ((state == IDLE) || frame_end);

  uart_parity_gen #(
    .WIDTH(DATA_BITS),
    .ODD  (PARITY_ODD != 0)
  ) u_parity (
    .data  (dataIn),
    .parity(parity_w)
  );

  always_ff @(posedge CLK288MHZ or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (fifoNE) state_next = START;
      START:  if (last_tick) state_next = DATA;
      DATA:   if (last_tick && (bit_cnt == DATA_LAST))
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (last_tick) state_next = STOP;
      STOP:   if (frame_end) state_next = fifoNE ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    readEn = pop;
    busy   = (state != IDLE);
    txDone = frame_end;
  end

  always_comb begin
    shreg_next = shreg;
    if (pop)                              shreg_next = dataIn;
    else if ((state == DATA) && last_tick) shreg_next = shreg >> 1;
  end

  // Line level is derived from the upcoming state so it changes on the same edge as the FSM.
  always_comb begin
    txd_next = 1'b1;
    unique case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shreg_next[0];
      PARITY:  txd_next = parity_q;
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK288MHZ or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_q    <= 1'b0;
      uart_txd_in <= 1'b1;
    end else begin
      shreg       <= shreg_next;
      uart_txd_in <= txd_next;
      if (pop) parity_q <= parity_w;
      if ((state_next != state) || (state == IDLE)) tick_cnt <= '0;
      else if (tick) tick_cnt <= last_tick ? '0 : tick_cnt + 1'b1;
      if (state_next != state) bit_cnt <= '0;
      else if (last_tick)      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - scoreboard bench for four uart_tx_param configurations
`timescale 1ns/1ps
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick = 1'b0;
  logic [3:0] ne = 4'b0;
  logic [8:0] din [4];
  wire  [3:0] re, txd, busy, done;

  int checks = 0;
  int errors = 0;

  // instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 7 data / 2 stop / x8
  int bc [4] = '{48, 48, 48, 24};
  int nb [4] = '{9, 10, 10, 9};

  logic [8:0] fmem [4][16];
  int head [4]   = '{default: 0};
  int tail [4]   = '{default: 0};
  int pushes [4] = '{default: 0};
  int pops [4]   = '{default: 0};
  int dones [4]  = '{default: 0};
  bit pend [4]   = '{default: 1'b0};
  int tcnt = 0;

  typedef struct {
    int          inst;
    logic [15:0] bits;
  } exp_t;
  exp_t sb [$];

  initial forever #5 clk = ~clk;

  uart_tx_param u_def (
    .CLK288MHZ(clk), .reset(reset), .tick(tick), .dataIn(din[0][7:0]), .fifoNE(ne[0]),
    .readEn(re[0]), .uart_txd_in(txd[0]), .busy(busy[0]), .txDone(done[0]));

  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .CLK288MHZ(clk), .reset(reset), .tick(tick), .dataIn(din[1][7:0]), .fifoNE(ne[1]),
    .readEn(re[1]), .uart_txd_in(txd[1]), .busy(busy[1]), .txDone(done[1]));

  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .CLK288MHZ(clk), .reset(reset), .tick(tick), .dataIn(din[2][7:0]), .fifoNE(ne[2]),
    .readEn(re[2]), .uart_txd_in(txd[2]), .busy(busy[2]), .txDone(done[2]));

  uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .STOP_BITS(2)) u_s2 (
    .CLK288MHZ(clk), .reset(reset), .tick(tick), .dataIn(din[3][6:0]), .fifoNE(ne[3]),
    .readEn(re[3]), .uart_txd_in(txd[3]), .busy(busy[3]), .txDone(done[3]));

  initial forever begin
    @(negedge clk);
    tick = (tcnt == 2);
    tcnt = (tcnt + 1) % 3;
  end

  // FIFO models: a pop seen in one cycle takes effect at the following negedge
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        head[i]++;
        pops[i]++;
      end
      ne[i]  = (head[i] != tail[i]);
      din[i] = fmem[i][head[i] % 16];
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      pend[i] = re[i];
      checks++;
      if (re[i] && (!ne[i] || reset)) begin
        errors++;
        $display("FAIL readEn_guard inst %0d: readEn=%b with fifoNE=%b reset=%b, required 0",
                 i, re[i], ne[i], reset);
      end
    end
  end

  task automatic push(input int i, input logic [8:0] w, input logic [15:0] bits, input bit expect_frame);
    exp_t e;
    fmem[i][tail[i] % 16] = w;
    tail[i]++;
    pushes[i]++;
    if (expect_frame) begin
      e.inst = i;
      e.bits = bits;
      sb.push_back(e);
    end
  endtask

  task automatic mon(input int i);
    logic        smp [1024];
    int          n = 0;
    int          k, slen;
    bit          in_frame = 0, prev_done = 0, b2b = 0, shape_ok, len_ok;
    logic [15:0] got, want;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        in_frame  = 0;
        prev_done = 0;
      end else begin
        if (!in_frame && txd[i] == 1'b0) begin
          in_frame = 1;
          n        = 0;
          b2b      = prev_done;
        end
        prev_done = 0;
        if (in_frame && n < 1024) begin
          smp[n] = txd[i];
          n++;
        end
        if (done[i]) begin
          dones[i]++;
          prev_done = 1;
          checks++;
          if (re[i] !== ne[i]) begin
            errors++;
            $display("FAIL readEn_at_txDone inst %0d: readEn=%b, required %b", i, re[i], ne[i]);
          end
          k = -1;
          for (int j = 0; j < sb.size(); j++)
            if (k < 0 && sb[j].inst == i) k = j;
          checks++;
          if (k < 0 || !in_frame) begin
            errors++;
            $display("FAIL frame_expected inst %0d: txDone with in_frame=%0d queued=%0d, required a queued frame",
                     i, in_frame, k >= 0);
          end else begin
            want = sb[k].bits;
            sb.delete(k);
            slen = n - nb[i] * bc[i];
            len_ok = b2b ? (slen == bc[i]) : (slen >= bc[i] - 2 && slen <= bc[i] + 2);
            checks++;
            if (!len_ok) begin
              errors++;
              $display("FAIL start_len inst %0d: %0d clocks (b2b=%0d), required %0d", i, slen, b2b, bc[i]);
            end
            shape_ok = (slen > 0);
            got = '0;
            if (shape_ok) begin
              for (int s = 0; s < slen; s++)
                if (smp[s] !== 1'b0) shape_ok = 0;
              for (int b = 0; b < nb[i]; b++) begin
                got[b] = smp[slen + b * bc[i]];
                for (int c = 0; c < bc[i]; c++)
                  if (smp[slen + b * bc[i] + c] !== got[b]) shape_ok = 0;
              end
            end
            checks++;
            if (!shape_ok) begin
              errors++;
              $display("FAIL bit_shape inst %0d: non-constant bit cells over %0d samples, required %0d-clock cells",
                       i, n, bc[i]);
            end
            checks++;
            if (got !== want) begin
              errors++;
              $display("FAIL frame_bits inst %0d: got %h, required %h", i, got, want);
            end
          end
          in_frame = 0;
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
      mon(3);
    join_none
  end

  task automatic wait_idle(input int budget);
    int  c = 0;
    bit  idle = 0;
    while (c < budget && !idle) begin
      @(negedge clk);
      c++;
      idle = (busy == 4'b0) && (sb.size() == 0);
      for (int i = 0; i < 4; i++)
        if (head[i] != tail[i] || pend[i]) idle = 0;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required idle", busy, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    push(0, 9'h0AC, 16'h01AC, 1);
    push(1, 9'h0AC, 16'h02AC, 1);
    push(2, 9'h0AC, 16'h03AC, 1);
    push(3, 9'h05A, 16'h01DA, 1);
    repeat (3) @(negedge clk);
    #3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({txd[i], busy[i], done[i], re[i]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_state inst %0d: txd,busy,done,readEn=%b, required 1000",
                 i, {txd[i], busy[i], done[i], re[i]});
      end
    end
    @(negedge clk);
    reset = 1'b0;
    wait_idle(2000);

    push(0, 9'h055, 16'h0155, 1);
    push(0, 9'h0AA, 16'h01AA, 1);
    wait_idle(3000);

    push(0, 9'h0C3, 16'h0000, 0);
    begin
      int c = 0;
      while (c < 20 && !busy[0]) begin
        @(negedge clk);
        c++;
      end
    end
    repeat (210) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({txd[0], busy[0]} !== 2'b10) begin
      errors++;
      $display("FAIL reset_abort: txd,busy=%b, required 10", {txd[0], busy[0]});
    end
    push(0, 9'h03C, 16'h013C, 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    wait_idle(2000);

    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dones[i] != ((i == 0) ? 4 : 1)) begin
        errors++;
        $display("FAIL txdone_count inst %0d: %0d, required %0d", i, dones[i], (i == 0) ? 4 : 1);
      end
      checks++;
      if (pops[i] != pushes[i]) begin
        errors++;
        $display("FAIL pop_count inst %0d: %0d, required %0d", i, pops[i], pushes[i]);
      end
      checks++;
      if ({txd[i], busy[i]} !== 2'b10) begin
        errors++;
        $display("FAIL final_idle inst %0d: txd,busy=%b, required 10", i, {txd[i], busy[i]});
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d frames left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, tick strobes per serial bit; legal range 4..64.
REQ-003 Parameter PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, number of stop bits; legal values 1 and 2.
REQ-006 Port CLK288MHZ, input, 1 bit, the only clock.
REQ-007 Port reset, input, 1 bit, asynchronous, active-high reset.
REQ-008 Port tick, input, 1 bit, one-cycle oversample strobe synchronous to CLK288MHZ.
REQ-009 Port dataIn, input, DATA_BITS bits, first-word-fall-through FIFO head; valid whenever fifoNE=1.
REQ-010 Port fifoNE, input, 1 bit, FIFO not empty.
REQ-011 Port readEn, output, 1 bit, one-cycle FIFO pop strobe.
REQ-012 Port uart_txd_in, output, 1 bit, registered serial line; idle level is 1.
REQ-013 Port busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-014 Port txDone, output, 1 bit, one-cycle pulse when the final stop bit completes.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, held in a registered state variable.
REQ-016 In IDLE with fifoNE=1, readEn SHALL be high combinationally in that cycle, dataIn SHALL be latched into the shift register on that edge, and the state SHALL become START.
REQ-017 readEn SHALL never be high in any cycle where fifoNE=0, and SHALL be high for at most one cycle per frame.
REQ-018 uart_txd_in SHALL be registered: 0 during START, the shift register LSB during DATA, the parity bit during PARITY, and 1 during STOP and IDLE.
REQ-019 Every bit state SHALL last exactly OVERSAMPLE tick strobes, counted by a tick counter of width clog2(OVERSAMPLE) that clears on every state change.
REQ-020 Data SHALL be sent LSB first; the shift register SHALL shift right on the last tick of each DATA bit, and a bit counter SHALL leave DATA after DATA_BITS bits.
REQ-021 Parity SHALL equal the XOR of the latched word, inverted when PARITY_ODD=1; the parity bit is computed at the latch edge.
REQ-022 DATA SHALL go to PARITY when PARITY_EN=1 and to STOP otherwise.
REQ-023 STOP SHALL last STOP_BITS*OVERSAMPLE ticks.
REQ-024 Back-to-back: on the final tick of STOP with fifoNE=1, readEn and txDone SHALL both pulse in that same cycle, and the state SHALL go directly to START with no idle bit.
REQ-025 On the final tick of STOP with fifoNE=0, txDone SHALL pulse and the state SHALL return to IDLE.
REQ-026 Changes to fifoNE or dataIn outside a pop cycle SHALL NOT affect the frame in flight.
REQ-027 The first START after IDLE MAY exceed OVERSAMPLE ticks by less than one tick period; every other bit SHALL be exact.

Reset
REQ-028 Reset SHALL asynchronously force state=IDLE, uart_txd_in=1, busy=0, txDone=0, readEn=0, and all counters and the shift register to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with the line returned to 1 and no FIFO pop while reset is high.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state enumeration and the default constants DATA_BITS, OVERSAMPLE and STOP_BITS.
REQ-031 A single sub-module, uart_parity_gen (parameterised width, odd/even), SHALL compute parity; no other hierarchy.

Verification
REQ-032 Defaults, tick every 3 clocks, dataIn=8'hAC, fifoNE=1 for exactly one pop -> line reads 0,0,0,1,1,0,1,0,1,1, each bit 48 clocks, one readEn, one txDone, busy low afterwards.
REQ-033 PARITY_EN=1 with 8'hAC -> parity bit 0 when PARITY_ODD=0 and 1 when PARITY_ODD=1; frame is 11 bits (528 clocks).
REQ-034 FIFO holding 8'h55 then 8'hAA -> two frames with zero idle gap, readEn coincident with the first txDone, two txDone pulses total.
REQ-035 DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=8 -> frame of 1+7+2 bits, stop high for 16 ticks.
REQ-036 Reset asserted during DATA bit 3 -> uart_txd_in=1 and busy=0 within the same cycle; after release with fifoNE=1, a fresh frame starts with exactly one readEn.
